// File: rtl/spmmio_blit_pkg.sv
// spmmio_blit_pkg -- shared definitions for the overlay-memory blitter.
//
// Contents:
//   state_t   : blitter FSM states (IDLE, WR, RD, FIN). RD only exists when
//               the copy feature is built in (macro SPMMIO_BLIT_COPY_EN).
//   OP_FILL / OP_COPY : encodings of cmd_op.
//   MEM_WORDS : number of 32-bit words in the overlay memory region.
//   SEL_ALL   : byte-select value used for every transfer (full words).
//   addr_inc  : word-address increment with wrap at MEM_WORDS.
package spmmio_blit_pkg;

    localparam int          MEM_WORDS = 4096;
    localparam int          AW        = 12;
    localparam logic [3:0]  SEL_ALL   = 4'b1111;

    localparam logic        OP_FILL   = 1'b0;
    localparam logic        OP_COPY   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
`ifdef SPMMIO_BLIT_COPY_EN
        RD   = 2'd2,
`endif
        FIN  = 2'd3
    } state_t;

    // The address width equals log2(MEM_WORDS), so the natural overflow of
    // the 12-bit add is the required modulo-4096 wrap.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return a + {{(AW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/spmmio_blit.sv
// spmmio_blit -- fill/copy engine driving the overlay MMIO responder.
//
// Optional feature macro: SPMMIO_BLIT_COPY_EN (copy command support).
//
// Ports:
//   clk, reset_n           : clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready  : command handshake (see below)
//   cmd_op                 : 0 = fill, 1 = copy
//   cmd_dst, cmd_src       : 12-bit word addresses (src used by copy only)
//   cmd_len                : word count 0..4096
//   cmd_pattern            : fill word
//   done, err              : one-cycle completion pulse, status of last command
//   adr, cs, sel, we, d    : bus initiator outputs (adr[0]=0, adr[12:1]=word)
//   q, ack                 : bus responder read data and transfer acknowledge
//   dbg_state              : current FSM state for observation
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only when the engine can take a
// new command (IDLE, or the FIN/done cycle). A bus transfer completes on a
// rising edge where cs and ack are both high; the bus outputs stay constant
// while cs is high and ack is low.
module spmmio_blit
    import spmmio_blit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [11:0] cmd_dst,
    input  logic [11:0] cmd_src,
    input  logic [12:0] cmd_len,
    input  logic [31:0] cmd_pattern,
    output logic        done,
    output logic        err,
    output logic [12:0] adr,
    output logic        cs,
    output logic [3:0]  sel,
    output logic        we,
    output logic [31:0] d,
    input  logic [31:0] q,
    input  logic        ack,
    output logic [1:0]  dbg_state
);

    localparam int             TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_live;      // low until the first clock after reset
    logic           r_err;
    logic [11:0]    r_dst;
    logic [12:0]    r_left;      // words still to be written
    logic [31:0]    r_wdata;     // fill pattern, or word captured by RD
    logic [TW-1:0]  r_tmo;       // cycles the current transfer has waited

    logic           w_cs;
    logic           w_accept;
    logic           w_tmo_hit;
    logic           w_last;
    logic           w_op_bad;    // command that must end at once with err=1

`ifdef SPMMIO_BLIT_COPY_EN
    logic           r_op;
    logic [11:0]    r_src;
    assign w_cs     = (r_state == WR) || (r_state == RD);
    assign w_op_bad = 1'b0;
`else
    logic           w_unused;
    assign w_unused = ^{cmd_src, q};
    assign w_cs     = (r_state == WR);
    assign w_op_bad = (cmd_op == OP_COPY);
`endif

    assign cmd_ready = r_live && ((r_state == IDLE) || (r_state == FIN));
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_last    = (r_left == 13'd1);
    // Only meaningful for non-zero timeouts; counter value 0 is the first
    // cycle cs is high for a transfer, so TMO_LAST is the final allowed one.
    assign w_tmo_hit = (TIMEOUT_CYCLES > 0) && w_cs && !ack && (r_tmo == TMO_LAST);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FIN: begin
                w_state_nxt = IDLE;
                if (w_accept) begin
                    if (cmd_len == 13'd0 || w_op_bad) begin
                        w_state_nxt = FIN;
`ifdef SPMMIO_BLIT_COPY_EN
                    end else if (cmd_op == OP_COPY) begin
                        w_state_nxt = RD;
`endif
                    end else begin
                        w_state_nxt = WR;
                    end
                end
            end
            WR: begin
                if (ack) begin
                    if (w_last) begin
                        w_state_nxt = FIN;
`ifdef SPMMIO_BLIT_COPY_EN
                    end else if (r_op == OP_COPY) begin
                        w_state_nxt = RD;
`endif
                    end else begin
                        w_state_nxt = WR;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = FIN;
                end
            end
`ifdef SPMMIO_BLIT_COPY_EN
            RD: begin
                if (ack) begin
                    w_state_nxt = WR;
                end else if (w_tmo_hit) begin
                    w_state_nxt = FIN;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live  <= 1'b0;
            r_err   <= 1'b0;
            r_dst   <= '0;
            r_left  <= '0;
            r_wdata <= '0;
            r_tmo   <= '0;
`ifdef SPMMIO_BLIT_COPY_EN
            r_op    <= OP_FILL;
            r_src   <= '0;
`endif
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_err   <= w_op_bad;
                r_dst   <= cmd_dst;
                r_left  <= cmd_len;
                r_wdata <= cmd_pattern;
                r_tmo   <= '0;
`ifdef SPMMIO_BLIT_COPY_EN
                r_op    <= cmd_op;
                r_src   <= cmd_src;
`endif
            end else begin
                // Counter restarts on every ack so each transfer gets a
                // full timeout window.
                if (w_cs) begin
                    r_tmo <= ack ? '0 : r_tmo + {{(TW-1){1'b0}}, 1'b1};
                end
                if (r_state == WR && ack) begin
                    r_dst  <= addr_inc(r_dst);
                    r_left <= r_left - 13'd1;
                end
`ifdef SPMMIO_BLIT_COPY_EN
                if (r_state == RD && ack) begin
                    r_src   <= addr_inc(r_src);
                    r_wdata <= q;
                end
`endif
                if (w_tmo_hit) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Bus outputs are decoded from registered state only, so they are
    // stable for the whole transfer and clear as soon as reset asserts.
    always_comb begin
        adr = '0;
        sel = '0;
        we  = 1'b0;
        d   = '0;
        if (r_state == WR) begin
            adr = {r_dst, 1'b0};
            sel = SEL_ALL;
            we  = 1'b1;
            d   = r_wdata;
        end
`ifdef SPMMIO_BLIT_COPY_EN
        if (r_state == RD) begin
            adr = {r_src, 1'b0};
            sel = SEL_ALL;
        end
`endif
    end

    assign cs        = w_cs;
    assign done      = (r_state == FIN);
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule
